uart_fifo_controller: RTL
=========================

UART_FIFO_CONTROLLER -- requirements
Module: uart_fifo_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-004 SHALL have parameter BAUD, default 115200, reset baud rate.
REQ-005 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries (power of 2, >=2).
REQ-006 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries (power of 2, >=2).
REQ-007 clk_i  in  1  single clock; all logic on its rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-010 wb_adr_i  in  ADDR_WIDTH; wb_dat_i  in  DATA_WIDTH; wb_sel_i  in  DATA_WIDTH/8.
REQ-011 wb_ack_o  out  1; wb_dat_o  out  DATA_WIDTH.
REQ-012 uart_txd_o  out  1  serial out, idle high; uart_rxd_i  in  1  asynchronous serial in.
REQ-013 irq_o  out  1  level interrupt.

Function
REQ-014 Register map on wb_adr_i[7:0]: 0x00 DATA, 0x05 STATUS, 0x08 DIV, 0x0C IER; other offsets: writes ignored, reads return 0, still acked.
REQ-015 wb_ack_o SHALL assert the cycle after wb_stb_i&wb_cyc_i while ack is low, hold exactly one cycle; a request is acted on only in its strobe cycle with ack low.
REQ-016 Byte-lane reads SHALL replicate the 8-bit register onto every lane selected by wb_sel_i; DATA write requires wb_sel_i[0].
REQ-017 DATA write SHALL push wb_dat_i[7:0] into TX FIFO; push when full SHALL be dropped, still acked.
REQ-018 DATA read SHALL return RX FIFO head and pop it; read when empty returns 0, no pop.
REQ-019 STATUS bits: [0] RX not empty, [1] overrun (sticky), [2] framing error (sticky), [5] TX FIFO not full, [6] TX idle (FIFO empty and shifter idle); others 0.
REQ-020 Writing STATUS with bit1/bit2 set SHALL clear that sticky flag (W1C).
REQ-021 DIV[15:0] = clocks per bit; reset value CLK_FREQ/BAUD; writes below 4 SHALL load 4; change takes effect at next frame start.
REQ-022 IER bit0 enables RX-not-empty, bit1 TX-FIFO-empty, bit2 overrun|framing; irq_o = OR of enabled sources, registered (one-cycle latency).
REQ-023 TX frame: start 0, 8 data bits LSB first, one stop 1, each exactly DIV clocks; next byte popped at end of stop bit, no idle gap when FIFO non-empty.
REQ-024 TX from idle SHALL drive start bit within 2 cycles of the push.
REQ-025 RX: 2-flop synchroniser; falling edge in idle starts frame; at DIV/2 start bit re-sampled, high aborts to idle.
REQ-026 RX data bits sampled every DIV clocks from start mid-point; stop sampled likewise; stop 0 SHALL set framing error and discard byte.
REQ-027 Valid byte arriving with RX FIFO full SHALL be discarded and set overrun; a pop in the same cycle SHALL make room (no overrun).
REQ-028 FIFO simultaneous push+pop SHALL keep count unchanged, also when full or (push-only effective) when empty; pointers wrap modulo depth.

Reset
REQ-029 On rst_i: wb_ack_o=0, wb_dat_o=0, uart_txd_o=1, irq_o=0, FIFOs empty, sticky flags 0, IER=0, DIV=CLK_FREQ/BAUD, TX/RX FSMs idle.
REQ-030 Reset mid-frame SHALL abandon the frame; uart_txd_o high from the cycle after rst_i sampled.

Structure
REQ-031 Package uart_pkg SHALL hold register offsets, STATUS bit indices, IER bit indices, DIV minimum, TX/RX state enums.
REQ-032 Sub-module uart_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated for TX and RX.

Verification
REQ-033 DIV=8, write 0x55 to DATA -> uart_txd_o emits 0,1,0,1,0,1,0,1,0,1, each 8 cycles; STATUS[6] returns 1 after stop.
REQ-034 Write 17 bytes rapidly, TX_DEPTH=16, DIV=8 -> first byte shifting, 16 queued, 17th... frames contiguous, no gap, 17 bytes exactly if 1st popped before 17th push, else 17th dropped.
REQ-035 Drive 0xA3 at DIV=8 on uart_rxd_i -> STATUS[0]=1, irq_o=1 with IER=1, DATA read 0xA3, then STATUS[0]=0.
REQ-036 Drive 17 bytes without reading, RX_DEPTH=16 -> STATUS[1]=1, 16 bytes read in order, write STATUS 0x02 clears it.
REQ-037 Frame with stop bit 0 -> STATUS[2]=1, RX FIFO unchanged; 2-cycle low glitch -> no frame.
REQ-038 Assert rst_i mid TX frame -> uart_txd_o=1 next cycle, STATUS reads 0x60, DIV reads CLK_FREQ/BAUD.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register map, status/interrupt bit positions and FSM state types for the UART controller
package uart_pkg;
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h05;
  localparam logic [7:0] REG_DIV    = 8'h08;
  localparam logic [7:0] REG_IER    = 8'h0C;
  localparam int ST_RX_NE   = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_FE      = 2;
  localparam int ST_TX_NF   = 5;
  localparam int ST_TX_IDLE = 6;
  localparam int IE_RX  = 0;
  localparam int IE_TX  = 1;
  localparam int IE_ERR = 2;
  localparam logic [15:0] DIV_MIN = 16'd4;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; push and pop together keep the count, pointers wrap at the power-of-2 depth
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  // pointer and occupancy bookkeeping; a pop frees the slot a same-cycle push needs when full
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage array, no reset needed since empty entries are never read out
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_fifo_controller.sv
// uart_fifo_controller: Wishbone-attached 8N1 UART with TX/RX FIFOs, sticky error flags and a level interrupt
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic                    wb_ack_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    uart_txd_o,
  input  logic                    uart_rxd_i,
  output logic                    irq_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / BAUD);
  logic req, wr, rd, unused;
  logic [7:0] adr, status, rd_byte;
  logic [15:0] div, wr_div;
  logic [2:0] ier;
  logic ovr, fe, rx_overrun, rx_frame_err;
  logic [DATA_WIDTH-1:0] rd_word, div_word;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  tx_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic txd_n, tx_tick;
  rx_state_t rx_state, rx_state_n;
  logic [1:0] rx_sync;
  logic rx_in, rx_prev, rx_tick;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;

  assign req = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign wr = req && wb_we_i;
  assign rd = req && !wb_we_i;
  assign adr = wb_adr_i[7:0];
  assign wr_div = 16'(wb_dat_i);
  assign tx_push = wr && adr == REG_DATA && wb_sel_i[0];
  assign rx_pop = rd && adr == REG_DATA;
  assign rx_overrun = rx_push && rx_full && !rx_pop;
  assign div_word = DATA_WIDTH'(div);
  assign unused = ^{wb_adr_i, wb_dat_i, tx_count, rx_count};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .pop(tx_pop), .din(wb_dat_i[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // status byte assembled from FIFO flags, sticky errors and transmitter activity
  always_comb begin
    status = '0;
    status[ST_RX_NE] = !rx_empty;
    status[ST_OVR] = ovr;
    status[ST_FE] = fe;
    status[ST_TX_NF] = !tx_full;
    status[ST_TX_IDLE] = tx_empty && tx_state == TX_IDLE;
  end
  assign rd_byte = adr == REG_DATA ? (rx_empty ? 8'h00 : rx_dout) :
                   adr == REG_STATUS ? status :
                   adr == REG_IER ? {5'b0, ier} : 8'h00;

  // read data: DIV comes back as a word, 8-bit registers are replicated onto each selected lane
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) rd_word[8*i +: 8] = wb_sel_i[i] ? (adr == REG_DIV ? div_word[8*i +: 8] : rd_byte) : 8'h00;
  end

  // bus handshake, control registers, sticky flags and registered interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      div <= DIV_RESET;
      ier <= '0;
      ovr <= 1'b0;
      fe <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rd_word : '0;
      if (wr && adr == REG_DIV) div <= wr_div < DIV_MIN ? DIV_MIN : wr_div;
      if (wr && adr == REG_IER) ier <= wb_dat_i[2:0];
      ovr <= rx_overrun || (ovr && !(wr && adr == REG_STATUS && wb_dat_i[ST_OVR]));
      fe <= rx_frame_err || (fe && !(wr && adr == REG_STATUS && wb_dat_i[ST_FE]));
      irq_o <= (ier[IE_RX] && !rx_empty) || (ier[IE_TX] && tx_empty) || (ier[IE_ERR] && (ovr || fe));
    end
  end

  assign tx_tick = tx_cnt == tx_div - 16'd1;
  // transmitter next state: a byte is loaded from idle or straight out of the stop bit so frames stay contiguous
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_cnt + 16'd1;
    tx_div_n = tx_div;
    tx_bit_n = tx_bit;
    tx_shift_n = tx_shift;
    txd_n = uart_txd_o;
    tx_pop = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        txd_n = 1'b1;
        tx_pop = !tx_empty;
      end
      TX_START: if (tx_tick) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_state_n = TX_DATA;
        txd_n = tx_shift[0];
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_n = '0;
        tx_bit_n = tx_bit + 3'd1;
        tx_shift_n = tx_shift >> 1;
        txd_n = tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
        tx_state_n = tx_bit == 3'd7 ? TX_STOP : TX_DATA;
      end
      TX_STOP: if (tx_tick) begin
        tx_cnt_n = '0;
        tx_state_n = TX_IDLE;
        txd_n = 1'b1;
        tx_pop = !tx_empty;
      end
    endcase
    if (tx_pop) begin
      tx_cnt_n = '0;
      tx_shift_n = tx_dout;
      tx_div_n = div;
      tx_state_n = TX_START;
      txd_n = 1'b0;
    end
  end

  // transmitter registers; the serial line is registered so it idles high right after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_div <= DIV_RESET;
      tx_bit <= '0;
      tx_shift <= '0;
      uart_txd_o <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_div <= tx_div_n;
      tx_bit <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_txd_o <= txd_n;
    end
  end

  assign rx_in = rx_sync[1];
  assign rx_tick = rx_cnt == rx_div - 16'd1;
  // receiver next state: validate start at its midpoint, then sample each bit one period apart
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_cnt + 16'd1;
    rx_div_n = rx_div;
    rx_bit_n = rx_bit;
    rx_shift_n = rx_shift;
    rx_push = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_in) begin
          rx_state_n = RX_START;
          rx_div_n = div;
        end
      end
      RX_START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_state_n = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_shift_n = {rx_in, rx_shift[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        rx_state_n = rx_bit == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_state_n = RX_IDLE;
        rx_push = rx_in;
        rx_frame_err = !rx_in;
      end
    endcase
  end

  // receiver registers including the two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_div <= DIV_RESET;
      rx_bit <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd_i};
      rx_prev <= rx_in;
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_div <= rx_div_n;
      rx_bit <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end
endmodule
